// File: rtl/branch_recovery_ctrl_if.sv
// Fetch/resolve handshake between the pipeline and the branch recovery controller.
// master = pipeline side, slave = branch_recovery_ctrl.
interface branch_recovery_ctrl_if;
   logic [31:0] fetch_pc;
   logic        predict_taken;
   logic        resolve_valid;
   logic [31:0] resolve_pc;
   logic        resolve_taken;
   logic        resolve_predicted;
   logic [31:0] resolve_target;
   logic        mistake;
   logic        flush;
   logic        pc_redirect_valid;
   logic [31:0] pc_redirect;
   logic        busy;

   modport master (
      output fetch_pc, resolve_valid, resolve_pc, resolve_taken, resolve_predicted, resolve_target,
      input  predict_taken, mistake, flush, pc_redirect_valid, pc_redirect, busy
   );

   modport slave (
      input  fetch_pc, resolve_valid, resolve_pc, resolve_taken, resolve_predicted, resolve_target,
      output predict_taken, mistake, flush, pc_redirect_valid, pc_redirect, busy
   );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// Bimodal branch predictor with misprediction recovery: one-cycle flush/redirect
// pulse followed by a refill window in which wrong-path resolutions are ignored.

// One 2-bit saturating counter of the predictor table.
module branch_recovery_ctr (
   input  logic       clk,
   input  logic       reset,
   input  logic       upd,
   input  logic       taken,
   output logic [1:0] cnt
);
   always_ff @(posedge clk) begin
      if (reset)                               cnt <= 2'b01;
      else if (upd &&  taken && cnt != 2'b11)  cnt <= cnt + 2'd1;
      else if (upd && !taken && cnt != 2'b00)  cnt <= cnt - 2'd1;
   end
endmodule

module branch_recovery_ctrl #(
   parameter int IDX_BITS      = 4,
   parameter int REFILL_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   branch_recovery_ctrl_if.slave br
);
   localparam int ENTRIES = 1 << IDX_BITS;

   typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, REFILL = 2'd2} state_t;

   state_t              state;
   logic [3:0]          refill_cnt;
   logic [31:0]         redirect;
   logic                mistake_q;
   logic                busy_q;
   logic [1:0]          ctr [ENTRIES];
   logic [IDX_BITS-1:0] fetch_idx;
   logic [IDX_BITS-1:0] upd_idx;
   logic                accept;
   logic                mispredict;
   logic                unused_pc_bits;

   assign fetch_idx  = br.fetch_pc[IDX_BITS+1:2];
   assign upd_idx    = br.resolve_pc[IDX_BITS+1:2];
   assign accept     = br.resolve_valid && (state == IDLE);
   assign mispredict = accept && (br.resolve_taken != br.resolve_predicted);

   assign unused_pc_bits = ^{br.fetch_pc[31:IDX_BITS+2], br.fetch_pc[1:0],
                             br.resolve_pc[31:IDX_BITS+2], br.resolve_pc[1:0]};

   // Lookup reads the counter before this edge's update lands, giving read-before-write.
   for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
      branch_recovery_ctr u_ctr (
         .clk   (clk),
         .reset (reset),
         .upd   (accept && (upd_idx == IDX_BITS'(i))),
         .taken (br.resolve_taken),
         .cnt   (ctr[i])
      );
   end

   assign br.predict_taken = ctr[fetch_idx][1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         refill_cnt <= '0;
         redirect   <= '0;
         mistake_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (mispredict) begin
               state     <= FLUSH;
               redirect  <= br.resolve_taken ? br.resolve_target : br.resolve_pc + 32'd4;
               mistake_q <= 1'b1;
               busy_q    <= 1'b1;
            end
            FLUSH: begin
               state      <= REFILL;
               refill_cnt <= 4'(REFILL_CYCLES);
               mistake_q  <= 1'b0;
            end
            REFILL: begin
               refill_cnt <= refill_cnt - 4'd1;
               if (refill_cnt == 4'd1) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // mistake_q is high only during FLUSH, so all three strobes share it.
   assign br.mistake           = mistake_q;
   assign br.flush             = mistake_q;
   assign br.pc_redirect_valid = mistake_q;
   assign br.pc_redirect       = mistake_q ? redirect : 32'd0;
   assign br.busy              = busy_q;
endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Scoreboard bench: driver runs a behavioural predictor/recovery model and queues
// expected redirect pulses; a negedge monitor pops and compares them.
module tb_branch_recovery_ctrl;
   localparam int IDX = 4;
   localparam int R   = 2;
   localparam int N   = 1 << IDX;

   typedef struct {
      logic [31:0] redirect;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   exp_t exp_q[$];
   int   tbl[N];
   int   busy_left;

   branch_recovery_ctrl_if bif();

   branch_recovery_ctrl #(.IDX_BITS(IDX), .REFILL_CYCLES(R)) dut (
      .clk   (clk),
      .reset (reset),
      .br    (bif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int idx(input logic [31:0] pc);
      return int'(pc[IDX+1:2]);
   endfunction

   task automatic model_reset();
      busy_left = 0;
      for (int i = 0; i < N; i++) tbl[i] = 1;
   endtask

   // One cycle: called at posedge+2, returns at the next posedge+2.
   task automatic step(input logic rst, input logic [31:0] fpc, input logic rv,
                       input logic [31:0] rpc, input logic rt, input logic rp,
                       input logic [31:0] tgt);
      reset                 = rst;
      bif.fetch_pc          = fpc;
      bif.resolve_valid     = rv;
      bif.resolve_pc        = rpc;
      bif.resolve_taken     = rt;
      bif.resolve_predicted = rp;
      bif.resolve_target    = tgt;
      #2;
      chk("predict_taken", {31'd0, bif.predict_taken}, (tbl[idx(fpc)] >= 2) ? 32'd1 : 32'd0);
      chk("busy", {31'd0, bif.busy}, (busy_left > 0) ? 32'd1 : 32'd0);
      if (rst) model_reset();
      else if (busy_left > 0) busy_left--;
      else if (rv) begin
         if (rt) tbl[idx(rpc)] = (tbl[idx(rpc)] == 3) ? 3 : tbl[idx(rpc)] + 1;
         else    tbl[idx(rpc)] = (tbl[idx(rpc)] == 0) ? 0 : tbl[idx(rpc)] - 1;
         if (rt != rp) begin
            busy_left = 1 + R;
            exp_q.push_back('{redirect: rt ? tgt : rpc + 32'd4, due: cyc + 1});
         end
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n, input logic [31:0] fpc);
      for (int i = 0; i < n; i++) step(1'b0, fpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bif.mistake || bif.flush || bif.pc_redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_pulse: got redirect %h expected no pulse (cycle %0d)",
                        bif.pc_redirect, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("pulse_cycle", cyc, e.due);
               chk("mistake", {31'd0, bif.mistake}, 32'd1);
               chk("flush", {31'd0, bif.flush}, 32'd1);
               chk("redirect_valid", {31'd0, bif.pc_redirect_valid}, 32'd1);
               chk("pc_redirect", bif.pc_redirect, e.redirect);
            end
         end else begin
            chk("pc_redirect_idle", bif.pc_redirect, 32'd0);
         end
      end
   end

   initial begin
      reset = 1'b1;
      bif.fetch_pc = '0; bif.resolve_valid = 1'b0; bif.resolve_pc = '0;
      bif.resolve_taken = 1'b0; bif.resolve_predicted = 1'b0; bif.resolve_target = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_mistake", {31'd0, bif.mistake}, 32'd0);
      chk("rst_flush", {31'd0, bif.flush}, 32'd0);
      chk("rst_redirect_valid", {31'd0, bif.pc_redirect_valid}, 32'd0);
      chk("rst_pc_redirect", bif.pc_redirect, 32'd0);
      chk("rst_busy", {31'd0, bif.busy}, 32'd0);
      chk("rst_predict", {31'd0, bif.predict_taken}, 32'd0);
      mon_en = 1'b1;

      // correct not-taken prediction
      step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      idle(2, 32'h100);
      // taken mispredict, then busy window
      step(1'b0, 32'h104, 1'b1, 32'h104, 1'b1, 1'b0, 32'h200);
      idle(4, 32'h104);
      // not-taken mispredict wrapping past 2^32
      step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
      idle(4, 32'hFFFF_FFFC);
      // wrong-path suppression: mismatch held through FLUSH and REFILL
      for (int i = 0; i < 2 + R + 1; i++)
         step(1'b0, 32'h110, 1'b1, 32'h110, 1'b1, 1'b0, 32'h300);
      idle(4, 32'h110);
      // saturation at 11
      for (int i = 0; i < 4; i++)
         step(1'b0, 32'h108, 1'b1, 32'h108, 1'b1, 1'b1, 32'h0);
      step(1'b0, 32'h108, 1'b1, 32'h108, 1'b0, 1'b1, 32'h0);
      idle(4, 32'h108);
      // read-before-write on the same entry
      step(1'b0, 32'h10C, 1'b1, 32'h10C, 1'b1, 1'b1, 32'h0);
      idle(1, 32'h10C);
      // reset during FLUSH
      step(1'b0, 32'h114, 1'b1, 32'h114, 1'b1, 1'b0, 32'h400);
      step(1'b1, 32'h114, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < N; i++) idle(1, 32'(i * 4));
      // reset coinciding with a mispredicting resolution
      step(1'b1, 32'h118, 1'b1, 32'h118, 1'b1, 1'b0, 32'h500);
      idle(4, 32'h118);

      for (int i = 0; i < 600; i++) begin
         logic [31:0] rpc, fpc;
         rpc = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFC : 32'h100 + 32'($urandom_range(0, 15)) * 4;
         fpc = 32'h100 + 32'($urandom_range(0, 15)) * 4;
         step($urandom_range(0, 79) == 0, fpc, $urandom_range(0, 1) == 1, rpc,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
      end
      idle(2 + R + 2, 32'h100);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
